// File: rtl/mips32i_ctrl_pkg.sv
// Shared types and encodings for the MIPS32i multi-cycle control FSM and its decoder.
package mips32i_ctrl_pkg;

  typedef enum logic [2:0] {
    StRst    = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ClsRtype   = 3'd0,
    ClsAluI    = 3'd1,
    ClsLoad    = 3'd2,
    ClsStore   = 3'd3,
    ClsBranch  = 3'd4,
    ClsJump    = 3'd5,
    ClsIllegal = 3'd6
  } instr_class_e;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7
  } alu_ctrl_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpSltiu = 6'h0B;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  localparam logic [1:0] PcSrcPlus4  = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  typedef struct packed {
    instr_class_e cls;
    logic         imm_zext;
    logic         alu_src_imm;
    alu_ctrl_e    alu_ctrl;
    logic         lui_sel;
    logic         reg_dst_rd;
    logic         mem_to_reg;
    logic         branch_ne;
  } ctrl_dec_t;

endpackage

// File: rtl/mips32i_ctrl_decode.sv
// Combinational opcode/funct decode into instruction class and static datapath selects.
module mips32i_ctrl_decode
  import mips32i_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_dec_t  dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.cls = ClsIllegal;
    case (opcode_i)
      OpRtype: begin
        dec_o.cls        = ClsRtype;
        dec_o.reg_dst_rd = 1'b1;
        case (funct_i)
          FnAdd, FnAddu: dec_o.alu_ctrl = AluAdd;
          FnSub, FnSubu: dec_o.alu_ctrl = AluSub;
          FnAnd:         dec_o.alu_ctrl = AluAnd;
          FnOr:          dec_o.alu_ctrl = AluOr;
          FnXor:         dec_o.alu_ctrl = AluXor;
          FnNor:         dec_o.alu_ctrl = AluNor;
          FnSlt:         dec_o.alu_ctrl = AluSlt;
          FnSltu:        dec_o.alu_ctrl = AluSltu;
          default: begin
            dec_o.cls        = ClsIllegal;
            dec_o.reg_dst_rd = 1'b0;
          end
        endcase
      end
      OpAddi, OpAddiu: begin
        dec_o.cls         = ClsAluI;
        dec_o.alu_src_imm = 1'b1;
        dec_o.alu_ctrl    = AluAdd;
      end
      OpSlti, OpSltiu: begin
        dec_o.cls         = ClsAluI;
        dec_o.alu_src_imm = 1'b1;
        dec_o.alu_ctrl    = (opcode_i == OpSlti) ? AluSlt : AluSltu;
      end
      OpAndi, OpOri, OpXori: begin
        dec_o.cls         = ClsAluI;
        dec_o.imm_zext    = 1'b1;
        dec_o.alu_src_imm = 1'b1;
        dec_o.alu_ctrl    = (opcode_i == OpAndi) ? AluAnd :
                            (opcode_i == OpOri)  ? AluOr  : AluXor;
      end
      OpLui: begin
        dec_o.cls         = ClsAluI;
        dec_o.alu_src_imm = 1'b1;
        dec_o.lui_sel     = 1'b1;
      end
      OpLw, OpSw: begin
        dec_o.cls         = (opcode_i == OpLw) ? ClsLoad : ClsStore;
        dec_o.alu_src_imm = 1'b1;
        dec_o.alu_ctrl    = AluAdd;
        dec_o.mem_to_reg  = (opcode_i == OpLw);
      end
      // Branches compare rs against rt by subtraction; alu_zero then decides.
      OpBeq, OpBne: begin
        dec_o.cls       = ClsBranch;
        dec_o.alu_ctrl  = AluSub;
        dec_o.branch_ne = (opcode_i == OpBne);
      end
      OpJ: dec_o.cls = ClsJump;
      default: dec_o.cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mips32i_multicycle_ctrl.sv
// Multi-cycle main control FSM with imem/dmem handshakes and wait timeout.
// Define MIPS32I_ILLEGAL_TRAP_EN to halt on illegal instructions and expose illegal_instr.
module mips32i_multicycle_ctrl
  import mips32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       imm_signext0_zeroext1,
  output logic       alu_src_imm,
  output logic [3:0] alu_ctrl,
  output logic       lui_sel,
  output logic       reg_dst_rd,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       bus_error,
`ifdef MIPS32I_ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_dec_t        dec_q, dec_d, dec_w;
  logic             bus_error_q, bus_error_d;
  logic             timeout_hit;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  mips32i_ctrl_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .dec_o    (dec_w)
  );

  // This cycle is the last permitted wait; an ack arriving now still wins.
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    dec_d       = dec_q;
    bus_error_d = bus_error_q;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PcSrcPlus4;
    reg_write = 1'b0;
    unique case (state_q)
      StRst: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout_hit) begin
          bus_error_d = 1'b1;
          state_d     = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        dec_d   = dec_w;
        state_d = StExec;
      end
      StExec: begin
        case (dec_q.cls)
          ClsBranch: begin
            pc_src   = PcSrcBranch;
            pc_write = dec_q.branch_ne ? !alu_zero : alu_zero;
            state_d  = StFetch;
          end
          ClsJump: begin
            pc_src   = PcSrcJump;
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsRtype, ClsAluI: state_d = StWb;
          default: begin
`ifdef MIPS32I_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = StHalt;
`else
            state_d   = StFetch;
`endif
          end
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (dec_q.cls == ClsStore);
        if (dmem_ack) begin
          state_d = (dec_q.cls == ClsStore) ? StFetch : StWb;
        end else if (timeout_hit) begin
          bus_error_d = 1'b1;
          state_d     = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRst;
      cnt_q       <= '0;
      dec_q       <= '0;
      bus_error_q <= 1'b0;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      bus_error_q <= bus_error_d;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign imm_signext0_zeroext1 = dec_q.imm_zext;
  assign alu_src_imm           = dec_q.alu_src_imm;
  assign alu_ctrl              = dec_q.alu_ctrl;
  assign lui_sel               = dec_q.lui_sel;
  assign reg_dst_rd            = dec_q.reg_dst_rd;
  assign mem_to_reg            = dec_q.mem_to_reg;
  assign bus_error             = bus_error_q;
  assign state_o               = state_q;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
  assign illegal_instr         = illegal_q;
`endif

endmodule

// File: tb/tb_mips32i_multicycle_ctrl.sv
// Directed table-driven bench for mips32i_multicycle_ctrl plus handshake/timeout/reset sequences.
module tb_mips32i_multicycle_ctrl;

  localparam int StRst = 0, StFetch = 1, StDecode = 2, StExec = 3, StMem = 4, StWb = 5,
                 StHalt = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       imm_signext0_zeroext1, alu_src_imm, lui_sel, reg_dst_rd, mem_to_reg, reg_write;
  logic [3:0] alu_ctrl;
  logic       bus_error;
  logic [2:0] state_o;
`ifdef MIPS32I_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips32i_multicycle_ctrl #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .opcode                (opcode),
    .funct                 (funct),
    .alu_zero              (alu_zero),
    .imem_ack              (imem_ack),
    .dmem_ack              (dmem_ack),
    .imem_req              (imem_req),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .ir_write              (ir_write),
    .pc_write              (pc_write),
    .pc_src                (pc_src),
    .imm_signext0_zeroext1 (imm_signext0_zeroext1),
    .alu_src_imm           (alu_src_imm),
    .alu_ctrl              (alu_ctrl),
    .lui_sel               (lui_sel),
    .reg_dst_rd            (reg_dst_rd),
    .mem_to_reg            (mem_to_reg),
    .reg_write             (reg_write),
    .bus_error             (bus_error),
`ifdef MIPS32I_ILLEGAL_TRAP_EN
    .illegal_instr         (illegal_instr),
`endif
    .state_o               (state_o)
  );

  typedef struct {
    int op, fn, az, chk_sel, cyc, alu, zext, src, lui, pcw, pcsrc, rw, m2r, rd, we;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Runs one instruction with zero-wait memory, starting and ending on a FETCH negedge.
  task automatic run_instr(input vec_t v, input int idx);
    int cyc, rw;
    logic [3:0] e_alu, w_alu;
    logic [1:0] e_pcsrc, f_pcsrc;
    logic e_zext, w_zext, e_src, e_lui, e_pcw, w_m2r, w_rd, we, f_irw, f_pcw;
    string nm;
    cyc = 0; rw = 0; e_alu = '0; w_alu = '0; e_pcsrc = '0; f_pcsrc = '1;
    e_zext = 0; w_zext = 0; e_src = 0; e_lui = 0; e_pcw = 0; w_m2r = 0; w_rd = 0; we = 0;
    f_irw = 0; f_pcw = 0;
    nm = $sformatf("v%0d_op%02h_fn%02h", idx, v.op, v.fn);
    opcode = v.op[5:0]; funct = v.fn[5:0]; alu_zero = v.az[0];
    imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    do begin
      if (state_o == 3'(StFetch)) begin
        f_irw = ir_write; f_pcw = pc_write; f_pcsrc = pc_src;
      end
      if (state_o == 3'(StExec)) begin
        e_alu = alu_ctrl; e_zext = imm_signext0_zeroext1; e_src = alu_src_imm;
        e_lui = lui_sel; e_pcw = pc_write; e_pcsrc = pc_src;
      end
      if (state_o == 3'(StWb)) begin
        w_alu = alu_ctrl; w_zext = imm_signext0_zeroext1; w_m2r = mem_to_reg; w_rd = reg_dst_rd;
      end
      rw += int'(reg_write);
      if (dmem_we) we = 1'b1;
      cyc++;
      step();
    end while (state_o != 3'(StFetch) && cyc < 20);
    chk({nm, "_cycles"}, cyc, v.cyc);
    chk({nm, "_fetch_ir_write"}, f_irw, 1);
    chk({nm, "_fetch_pc_write"}, f_pcw, 1);
    chk({nm, "_fetch_pc_src"}, f_pcsrc, 0);
    chk({nm, "_reg_write_cnt"}, rw, v.rw);
    chk({nm, "_dmem_we"}, we, v.we);
    chk({nm, "_lui_sel"}, e_lui, v.lui);
    chk({nm, "_exec_pc_write"}, e_pcw, v.pcw);
    chk({nm, "_wb_mem_to_reg"}, w_m2r, v.m2r);
    chk({nm, "_wb_reg_dst_rd"}, w_rd, v.rd);
    if (v.chk_sel != 0) begin
      chk({nm, "_exec_alu_ctrl"}, e_alu, v.alu);
      chk({nm, "_exec_zext"}, e_zext, v.zext);
      chk({nm, "_exec_alu_src_imm"}, e_src, v.src);
      if (v.rw != 0) begin
        chk({nm, "_wb_alu_ctrl"}, w_alu, v.alu);
        chk({nm, "_wb_zext"}, w_zext, v.zext);
      end
    end
    if (v.op == 'h02 || v.op == 'h04 || v.op == 'h05)
      chk({nm, "_exec_pc_src"}, e_pcsrc, v.pcsrc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //             op   fn  az sel cyc alu zx src lui pcw pcs rw m2r rd we
    vecs.push_back('{'h0D, 0,   0, 1, 4, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0});  // ori
    vecs.push_back('{'h08, 0,   0, 1, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0});  // addi
    vecs.push_back('{'h09, 0,   0, 1, 4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0});  // addiu
    vecs.push_back('{'h0C, 0,   0, 1, 4, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0});  // andi
    vecs.push_back('{'h0E, 0,   0, 1, 4, 4, 1, 1, 0, 0, 0, 1, 0, 0, 0});  // xori
    vecs.push_back('{'h0A, 0,   0, 1, 4, 6, 0, 1, 0, 0, 0, 1, 0, 0, 0});  // slti
    vecs.push_back('{'h0B, 0,   0, 1, 4, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0});  // sltiu
    vecs.push_back('{'h0F, 0,   0, 0, 4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0});  // lui
    vecs.push_back('{'h00, 'h20, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // add
    vecs.push_back('{'h00, 'h23, 0, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // subu
    vecs.push_back('{'h00, 'h24, 0, 1, 4, 2, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // and
    vecs.push_back('{'h00, 'h25, 0, 1, 4, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // or
    vecs.push_back('{'h00, 'h26, 0, 1, 4, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // xor
    vecs.push_back('{'h00, 'h27, 0, 1, 4, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // nor
    vecs.push_back('{'h00, 'h2A, 0, 1, 4, 6, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // slt
    vecs.push_back('{'h00, 'h2B, 0, 1, 4, 7, 0, 0, 0, 0, 0, 1, 0, 1, 0}); // sltu
    vecs.push_back('{'h23, 0,   0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0});  // lw
    vecs.push_back('{'h2B, 0,   0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1});  // sw
    vecs.push_back('{'h04, 0,   1, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0});  // beq taken
    vecs.push_back('{'h04, 0,   0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});  // beq not taken
    vecs.push_back('{'h05, 0,   1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});  // bne not taken
    vecs.push_back('{'h05, 0,   0, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0});  // bne taken
    vecs.push_back('{'h02, 0,   0, 0, 3, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0});  // j
`ifndef MIPS32I_ILLEGAL_TRAP_EN
    vecs.push_back('{'h3F, 0,   0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});  // bad opcode
    vecs.push_back('{'h00, 'h3F, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}); // bad funct
`endif

    // Reset state
    step(); step();
    chk("rst_state", state_o, StRst);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_bus_error", bus_error, 0);
    rst_n = 1'b1;
    step();
    chk("rst_to_fetch", state_o, StFetch);

    foreach (vecs[i]) run_instr(vecs[i], i);

    // lw with dmem_ack on the fourth request cycle (also the last allowed wait)
    opcode = 6'h23; funct = '0; imem_ack = 1'b1; dmem_ack = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && state_o != 3'(StMem); k++) step();
    for (int k = 0; k < 10 && state_o == 3'(StMem); k++) begin
      cnt += int'(dmem_req);
      dmem_ack = (cnt == 4);
      step();
    end
    dmem_ack = 1'b0;
    chk("lw_wait_req_cycles", cnt, 4);
    chk("lw_wait_state_wb", state_o, StWb);
    chk("lw_wait_mem_to_reg", mem_to_reg, 1);
    chk("lw_wait_reg_write", reg_write, 1);
    step();
    chk("lw_wait_back_fetch", state_o, StFetch);
    chk("lw_wait_bus_error", bus_error, 0);

    // imem_ack arriving in the final permitted FETCH wait cycle beats the timeout
    opcode = 6'h0D; imem_ack = 1'b0; dmem_ack = 1'b0;
    step(); step(); step();
    imem_ack = 1'b1;
    #1;
    chk("fetch_limit_ir_write", ir_write, 1);
    step();
    chk("fetch_limit_decode", state_o, StDecode);
    chk("fetch_limit_bus_error", bus_error, 0);
    for (int k = 0; k < 10 && state_o != 3'(StFetch); k++) step();
    chk("fetch_limit_back_fetch", state_o, StFetch);

    // Reset during MEM of sw drops the request
    opcode = 6'h2B; imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int k = 0; k < 10 && state_o != 3'(StMem); k++) step();
    chk("sw_rst_in_mem", state_o, StMem);
    chk("sw_rst_dmem_we", dmem_we, 1);
    rst_n = 1'b0;
    step();
    chk("sw_rst_state", state_o, StRst);
    chk("sw_rst_dmem_req", dmem_req, 0);
    rst_n = 1'b1;
    step();
    chk("sw_rst_fetch", state_o, StFetch);

`ifdef MIPS32I_ILLEGAL_TRAP_EN
    opcode = 6'h3F; imem_ack = 1'b1;
    step(); step(); step();
    chk("illegal_halt", state_o, StHalt);
    chk("illegal_flag", illegal_instr, 1);
    chk("illegal_no_req", imem_req, 0);
    step(); step();
    chk("illegal_sticky", illegal_instr, 1);
    rst_n = 1'b0;
    step();
    chk("illegal_rst_clear", illegal_instr, 0);
    rst_n = 1'b1;
    step();
    chk("illegal_rst_fetch", state_o, StFetch);
`endif

    // Fetch timeout: four unanswered request cycles, then HALT
    opcode = 6'h0D; imem_ack = 1'b0; dmem_ack = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && state_o == 3'(StFetch); k++) begin
      cnt += int'(imem_req);
      step();
    end
    chk("timeout_wait_cycles", cnt, 4);
    chk("timeout_halt", state_o, StHalt);
    chk("timeout_bus_error", bus_error, 1);
    chk("timeout_imem_req", imem_req, 0);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    step(); step(); step();
    chk("halt_ignores_ack_state", state_o, StHalt);
    chk("halt_ir_write", ir_write, 0);
    chk("halt_pc_write", pc_write, 0);
    chk("halt_bus_error_sticky", bus_error, 1);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b0;
    step();
    chk("halt_rst_state", state_o, StRst);
    chk("halt_rst_bus_error", bus_error, 0);
    chk("halt_rst_imem_req", imem_req, 0);
    rst_n = 1'b1;
    step();
    chk("halt_rst_fetch", state_o, StFetch);
    chk("halt_rst_fetch_req", imem_req, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
